// File: rtl/arb_pkg.sv
// Shared definitions for the bus arbiter slice.
//   arb_state_e         : FSM state encoding (IDLE / GRANTED / RELEASE)
//   ARB_DEFAULT_TIMEOUT : default watchdog length in granted cycles
//   ARB_MIN_CORES/ARB_MAX_CORES : supported requester count range
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam int ARB_DEFAULT_TIMEOUT = 1024;
    localparam int ARB_MIN_CORES       = 2;
    localparam int ARB_MAX_CORES       = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
// Searches req_i starting at index start_i (wrapping modulo N) and returns
// the first set bit.
//   req_i    : request vector
//   start_i  : index where the search begins (must be < N)
//   found_o  : at least one request is set
//   idx_o    : winner index
//   onehot_o : winner as a one-hot vector (zero when nothing found)
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    logic [2*N-1:0] dbl_req;
    logic [N-1:0]   rot_req;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    // Duplicating the vector turns the wrap-around into a plain slice:
    // bit i of rot_req is request (start_i + i) mod N.
    assign dbl_req = {req_i, req_i};
    assign rot_req = dbl_req[start_i +: N];

    // Lowest set bit of the rotated vector; scanning downwards lets the
    // last hit (the lowest index) win without needing an early exit.
    always_comb begin
        found_o = 1'b0;
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                found_o = 1'b1;
                offset  = IDX_W'(i);
            end
        end
    end

    // Undo the rotation; the sum is one bit wider so it cannot overflow
    // before the modulo-N correction.
    always_comb begin
        sum = {1'b0, start_i} + {1'b0, offset};
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        idx_o    = sum[IDX_W-1:0];
        onehot_o = found_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with grant hold and stall watchdog.
// Handshake: a core raises Bus_RQ and keeps it high for as long as it
// needs the bus; the arbiter answers with a registered one-hot Bus_GRANT
// that stays asserted until the owner drops Bus_RQ or the watchdog revokes
// it. Every ownership change passes through one cycle with no grant.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   Bus_RQ        : per-core request
//   Bus_Ready     : transfer-complete strobe, restarts the watchdog
//   Bus_GRANT     : one-hot grant (registered)
//   Bus_Owner     : index of the current/last grantee (registered)
//   Bus_Busy      : any grant asserted
//   Timeout_Err   : one-cycle pulse when the watchdog revokes a grant
//   dbg_state_o   : current FSM state for observation
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int TIMEOUT = ARB_DEFAULT_TIMEOUT,
    parameter int IDX_W   = $clog2(N_CORES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_CORES-1:0] Bus_RQ,
    input  logic               Bus_Ready,
    output logic [N_CORES-1:0] Bus_GRANT,
    output logic [IDX_W-1:0]   Bus_Owner,
    output logic               Bus_Busy,
    output logic               Timeout_Err,
    output arb_state_e         dbg_state_o
);

    // The counter only needs to reach TIMEOUT-1; it saturates at all-ones.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_e           state_q, state_d;
    logic [N_CORES-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q,  last_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 err_q,   err_d;

    logic [IDX_W-1:0]     rr_start;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [N_CORES-1:0]   pick_onehot;

    // Search begins just after the previous owner so it gets lowest priority.
    assign rr_start = (last_q == IDX_W'(N_CORES - 1)) ? '0 : last_q + IDX_W'(1);

    rr_priority_pick #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (Bus_RQ),
        .start_i  (rr_start),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(N_CORES - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        unique case (state_q)
            ARB_IDLE, ARB_RELEASE: begin
                if (pick_found) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_GRANTED;
                end else begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            end

            ARB_GRANTED: begin
                // A dropped request wins over the watchdog, so a release
                // that coincides with the last allowed cycle is not an error.
                if (!Bus_RQ[owner_q]) begin
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = ARB_RELEASE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST) && !Bus_Ready) begin
                    grant_d = '0;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                    state_d = ARB_RELEASE;
                end else if (Bus_Ready) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign Bus_GRANT   = grant_q;
    assign Bus_Owner   = owner_q;
    assign Bus_Busy    = |grant_q;
    assign Timeout_Err = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (watchdog of 8 cycles, watchdog off)
// share one stimulus stream. Each cycle the driver advances an abstract
// reference model and queues the expected outputs; a monitor pops and
// compares after every rising edge.
module tb_bus_arbiter;
    import arb_pkg::*;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [N-1:0] Bus_RQ;
    logic         Bus_Ready;

    logic [N-1:0] grant_w, grant_n;
    logic [1:0]   owner_w, owner_n;
    logic         busy_w, busy_n;
    logic         err_w, err_n;
    arb_state_e   st_w, st_n;

    bus_arbiter #(.N_CORES(N), .TIMEOUT(8)) u_wd (
        .clock(clk), .reset(reset), .Bus_RQ(Bus_RQ), .Bus_Ready(Bus_Ready),
        .Bus_GRANT(grant_w), .Bus_Owner(owner_w), .Bus_Busy(busy_w),
        .Timeout_Err(err_w), .dbg_state_o(st_w)
    );

    bus_arbiter #(.N_CORES(N), .TIMEOUT(0)) u_nw (
        .clock(clk), .reset(reset), .Bus_RQ(Bus_RQ), .Bus_Ready(Bus_Ready),
        .Bus_GRANT(grant_n), .Bus_Owner(owner_n), .Bus_Busy(busy_n),
        .Timeout_Err(err_n), .dbg_state_o(st_n)
    );

    // ---------------- scoreboard state ----------------
    // entry layout: {err, busy, owner[1:0], grant[3:0]}
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int busy_wd_n = 0, err_wd_n = 0, busy_nw_n = 0, err_nw_n = 0;
    bit log_en = 0;
    int order_q[$];

    // ---------------- reference model ----------------
    // owner = -1 means nobody holds the bus; stall counts granted cycles
    // since the grant or the last Bus_Ready.
    int m_own[2];
    int m_last[2];
    int m_out[2];
    int m_stall[2];
    int m_to[2] = '{8, 0};

    function automatic logic [7:0] model_step(input int m, input logic [3:0] rq,
                                              input logic rdy, input logic rst);
        logic err;
        int   c;
        err = 1'b0;
        if (rst) begin
            m_own[m] = -1; m_last[m] = N - 1; m_out[m] = 0; m_stall[m] = 0;
        end else if (m_own[m] >= 0) begin
            if (!rq[m_own[m]]) begin
                m_last[m] = m_own[m]; m_own[m] = -1;
            end else if (m_to[m] != 0 && m_stall[m] == m_to[m] - 1 && !rdy) begin
                m_last[m] = m_own[m]; m_own[m] = -1; err = 1'b1;
            end else begin
                m_stall[m] = rdy ? 0 : m_stall[m] + 1;
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                c = (m_last[m] + i) % N;
                if (rq[c]) begin
                    m_own[m] = c; m_out[m] = c; m_stall[m] = 0;
                    break;
                end
            end
        end
        return {err, (m_own[m] >= 0), 2'(m_out[m]),
                (m_own[m] >= 0) ? 4'(1 << m_own[m]) : 4'b0000};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] rq, input logic rdy, input logic rst);
        @(negedge clk);
        Bus_RQ    = rq;
        Bus_Ready = rdy;
        reset     = rst;
        exp_q0.push_back(model_step(0, rq, rdy, rst));
        exp_q1.push_back(model_step(1, rq, rdy, rst));
    endtask

    task automatic clear_counts();
        busy_wd_n = 0; err_wd_n = 0; busy_nw_n = 0; err_nw_n = 0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [7:0] e;
        logic [3:0] prev_grant_n;
        prev_grant_n = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                chk("wd_grant", 32'(grant_w), 32'(e[3:0]));
                chk("wd_owner", 32'(owner_w), 32'(e[5:4]));
                chk("wd_busy",  32'(busy_w),  32'(e[6]));
                chk("wd_err",   32'(err_w),   32'(e[7]));
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                chk("nw_grant", 32'(grant_n), 32'(e[3:0]));
                chk("nw_owner", 32'(owner_n), 32'(e[5:4]));
                chk("nw_busy",  32'(busy_n),  32'(e[6]));
                chk("nw_err",   32'(err_n),   32'(e[7]));
            end
            if (busy_w) busy_wd_n++;
            if (err_w)  err_wd_n++;
            if (busy_n) busy_nw_n++;
            if (err_n)  err_nw_n++;
            if (log_en && grant_n != 0 && prev_grant_n == 0) order_q.push_back(int'(owner_n));
            prev_grant_n = grant_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        logic [3:0] drop;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] rq_r;

        reset = 1'b1; Bus_RQ = '0; Bus_Ready = 1'b0;
        drive(4'b0000, 0, 1);
        drive(4'b0000, 0, 1);
        drive(4'b0000, 0, 0);
        chk("reset_state_wd", 32'(st_w), 32'(ARB_IDLE));
        chk("reset_state_nw", 32'(st_n), 32'(ARB_IDLE));
        drive(4'b0000, 0, 0);

        // single requester, 5 cycles
        clear_counts();
        drive(4'b0100, 0, 0);
        drive(4'b0100, 0, 0);
        chk("single_state_granted", 32'(st_n), 32'(ARB_GRANTED));
        repeat (3) drive(4'b0100, 0, 0);
        repeat (4) drive(4'b0000, 0, 0);
        chk("single_busy_cycles_nw", 32'(busy_nw_n), 32'd5);
        chk("single_busy_cycles_wd", 32'(busy_wd_n), 32'd5);

        // fairness from a fresh reset
        drive(4'b0000, 0, 1);
        drive(4'b0000, 0, 0);
        order_q.delete();
        log_en = 1;
        hold = 0; drop = '0;
        repeat (30) begin
            logic [3:0] rq;
            rq   = 4'hF & ~drop;
            drop = '0;
            drive(rq, 0, 0);
            if (m_own[1] >= 0) begin
                hold++;
                if (hold == 3) begin
                    drop = 4'(1 << m_own[1]);
                    hold = 0;
                end
            end else begin
                hold = 0;
            end
        end
        repeat (4) drive(4'b0000, 0, 0);
        log_en = 0;
        chk("fair_enough_grants", 32'(order_q.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < order_q.size(); i++)
            chk("fair_order", 32'(order_q[i]), 32'(exp_order[i]));

        // watchdog: stall with no Bus_Ready
        clear_counts();
        repeat (9) drive(4'b0010, 0, 0);
        repeat (4) drive(4'b0000, 0, 0);
        chk("wd_err_pulses", 32'(err_wd_n), 32'd1);
        chk("wd_busy_cycles", 32'(busy_wd_n), 32'd8);
        chk("nw_busy_cycles", 32'(busy_nw_n), 32'd9);
        chk("nw_err_pulses", 32'(err_nw_n), 32'd0);

        // watchdog kept alive by Bus_Ready every 5 cycles
        clear_counts();
        for (int i = 0; i < 30; i++) drive(4'b0010, (i % 5 == 4), 0);
        repeat (4) drive(4'b0000, 0, 0);
        chk("wd_ready_no_err", 32'(err_wd_n), 32'd0);
        chk("wd_ready_busy_cycles", 32'(busy_wd_n), 32'd30);

        // no preemption: core 3 owns, core 0 waits
        order_q.delete();
        log_en = 1;
        repeat (3) drive(4'b1000, 0, 0);
        repeat (3) drive(4'b1001, 0, 0);
        repeat (3) drive(4'b0001, 0, 0);
        repeat (4) drive(4'b0000, 0, 0);
        log_en = 0;
        chk("nopreempt_grants", 32'(order_q.size()), 32'd2);
        if (order_q.size() >= 2) begin
            chk("nopreempt_first", 32'(order_q[0]), 32'd3);
            chk("nopreempt_second", 32'(order_q[1]), 32'd0);
        end

        // simultaneous drop+ready, then ready on the timeout cycle
        clear_counts();
        repeat (3) drive(4'b0100, 0, 0);
        drive(4'b0000, 1, 0);
        drive(4'b0000, 0, 0);
        for (int i = 1; i <= 12; i++) drive(4'b0010, (i == 9), 0);
        drive(4'b0000, 1, 0);
        repeat (4) drive(4'b0000, 0, 0);
        chk("simul_no_err", 32'(err_wd_n), 32'd0);
        chk("simul_busy_cycles", 32'(busy_wd_n), 32'd15);

        // reset mid-grant, then core 0 first
        repeat (3) drive(4'b0010, 0, 0);
        order_q.delete();
        log_en = 1;
        drive(4'b0011, 0, 1);
        repeat (4) drive(4'b0011, 0, 0);
        repeat (4) drive(4'b0000, 0, 0);
        log_en = 0;
        chk("reset_regrant_seen", 32'(order_q.size() >= 1), 32'd1);
        if (order_q.size() >= 1) chk("reset_regrant_core0", 32'(order_q[0]), 32'd0);

        // randomized traffic
        rq_r = '0;
        repeat (500) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) rq_r[c] = ~rq_r[c];
            drive(rq_r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 149) == 0));
        end
        repeat (4) drive(4'b0000, 0, 0);

        @(posedge clk);
        #2;
        chk("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter at the far end of the request/grant handshake that each core's arbitration submodule drives. It receives one bus request per core and issues at most one registered, one-hot grant, using round-robin fairness. A grant is held for as long as the owner keeps its request high. A watchdog revokes a grant that stalls without memory progress. One instance serves the data bus and one serves the instruction bus.

## Interface
- `N_CORES`, default 4: number of requesters, valid range 2–16.
- `TIMEOUT`, default 1024: cycles a grant may remain held without `Bus_Ready`; 0 disables the watchdog.
- `IDX_W`, default `$clog2(N_CORES)`: width of the owner index (derived, not overridden).

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `Bus_RQ`, in, N_CORES: per-core request (the `D_Bus_RQ`/`I_Bus_RQ` signal of each core).
- `Bus_Ready`, in, 1: memory/bus transfer-complete strobe from the shared bus.
- `Bus_GRANT`, out, N_CORES: one-hot grant, registered.
- `Bus_Owner`, out, IDX_W: index of the current grantee, for the bus mux select.
- `Bus_Busy`, out, 1: high while any grant is asserted.
- `Timeout_Err`, out, 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- The FSM has three states: IDLE, GRANTED and RELEASE.
- **IDLE and RELEASE:** at each edge, if `Bus_RQ != 0`, pick the winner by round-robin, set `Bus_GRANT[winner]`, load `Bus_Owner`, clear the watchdog counter and go to GRANTED. Otherwise go to (or stay in) IDLE.
- **Round-robin:** the search starts at `last_owner+1` modulo N_CORES and takes the first set request bit. `last_owner` resets to N_CORES-1, so core 0 has first priority after reset.
- **GRANTED, request dropped:** if `Bus_RQ[owner]==0`, clear the grant, set `last_owner = owner` and go to RELEASE.
- **GRANTED, watchdog expired:** if `TIMEOUT != 0` and the counter reaches TIMEOUT-1 with no `Bus_Ready` that cycle, clear the grant, pulse `Timeout_Err`, set `last_owner = owner` and go to RELEASE.
- **GRANTED, otherwise:** hold the grant. The counter clears on `Bus_Ready` and increments otherwise. It saturates and never wraps.
- **Other requesters:** requests from non-owners during GRANTED are ignored. There is no preemption other than the watchdog.
- **Timed-out core still requesting:** it re-enters arbitration normally, but the advanced pointer gives every other requester priority first.
- **Invariants:** `Bus_GRANT` is always zero or one-hot. `Bus_Owner` holds its last value when no grant is active. `Bus_Busy = |Bus_GRANT`.
- **Reset values:** `Bus_GRANT=0`, `Bus_Owner=0`, `Bus_Busy=0`, `Timeout_Err=0`, state IDLE, counter 0.
- **Reset mid-grant:** the grant drops on the reset edge with no `Timeout_Err`. Pointer and counter return to their reset values.

## Timing
- **Grant latency:** a request sampled high at edge k in IDLE gives `Bus_GRANT` high after edge k (one cycle).
- **Release:** the owner drops its request before edge k; the grant is low after edge k; the RELEASE cycle follows.
- **Dead cycle:** exactly one cycle with no grant separates consecutive owners. This lets the bus mux settle.
- **Back-to-back:** a request sampled in RELEASE is granted at the next edge, so a new grant appears two edges after the previous owner's request drops.
- **Watchdog:** the timeout fires on the TIMEOUT-th consecutive granted cycle without `Bus_Ready`. `Bus_Ready` in that same cycle prevents the timeout.
- **Simultaneous `Bus_Ready` and request drop:** treated as a normal release with no error.
- No combinational path from inputs to outputs.

## Structure
- **Shared package `arb_pkg`:**
  - state encoding constants `ARB_IDLE=2'd0`, `ARB_GRANTED=2'd1`, `ARB_RELEASE=2'd2`;
  - default `TIMEOUT`;
  - `N_CORES` limit.
- **Sub-module `rr_priority_pick`:**
  - combinational;
  - inputs: request vector and start index;
  - outputs: `found`, winner index and one-hot vector;
  - implemented as a double-width rotate-and-priority-encode.
- **Top level:** FSM, registered outputs, pointer and watchdog counter.

## Test plan
All scenarios use N_CORES=4.

- Single requester, watchdog off (TIMEOUT=0): `Bus_RQ=4'b0100` for 5 cycles, then 0 → `Bus_GRANT=4'b0100` from cycle 1 to cycle 5, `Bus_Owner=2`, then one RELEASE cycle, then IDLE.
- Fairness: `Bus_RQ=4'b1111` held, each owner drops its request after 3 granted cycles and re-raises it one cycle later → grant order 0,1,2,3,0, with one dead cycle between owners.
- Watchdog with TIMEOUT=8: core 1 holds its request and `Bus_Ready` stays 0 → grant revoked after 8 cycles and `Timeout_Err` pulses once. With `Bus_Ready` pulsed every 5 cycles, the grant is never revoked.
- No preemption: core 3 is granted and core 0 raises its request mid-grant → core 0 is granted only after the RELEASE that follows core 3's drop.
- Simultaneous events: the owner drops its request in the same cycle as `Bus_Ready`, and the timeout cycle coincides with `Bus_Ready` → no `Timeout_Err`; normal release, or the grant is held, respectively.
- Reset mid-grant: assert `reset` while `Bus_GRANT=4'b0010` → all outputs are 0 after the edge. With `Bus_RQ=4'b0011` after reset, core 0 is granted first.
